// File: rtl/gf_add_pkg.sv
// Shared definitions for the pipelined GF/integer adder.
//   MODE_INT / MODE_GF : per-beat operation select carried with each beat
//   seg_width()        : bits handled by each pipeline segment
//   stage_ctl_t        : per-stage control register (valid, mode, carry)
package gf_add_pkg;

    typedef enum logic {
        MODE_INT = 1'b0,
        MODE_GF  = 1'b1
    } gf_mode_e;

    function automatic int unsigned seg_width(input int unsigned data_width,
                                              input int unsigned num_stages);
        return data_width / num_stages;
    endfunction

    typedef struct packed {
        logic valid;
        logic mode;
        logic carry;
    } stage_ctl_t;

endpackage

// File: rtl/add_slice.sv
// SEG-bit combinational ripple adder slice.
//   a, b    : operand slices
//   ci      : carry into the slice
//   gf_mode : MODE_GF suppresses every carry so sum = a ^ b and co = 0
//   sum     : slice result
//   co      : carry out of the slice
module add_slice
    import gf_add_pkg::*;
#(
    parameter int unsigned SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    input  logic           gf_mode,
    output logic [SEG-1:0] sum,
    output logic           co
);

    logic         w_gf;
    logic [SEG:0] w_c;

    assign w_gf = (gf_mode == MODE_GF);

    always_comb begin
        w_c    = '0;
        sum    = '0;
        w_c[0] = ci & ~w_gf;
        for (int unsigned i = 0; i < SEG; i++) begin
            sum[i]   = a[i] ^ b[i] ^ w_c[i];
            w_c[i+1] = ~w_gf & ((a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i])));
        end
        co = w_c[SEG];
    end

endmodule

// File: rtl/pipelined_gf_adder.sv
// Pipelined integer / GF(2^m) adder with valid/ready on both sides.
// The add is split into NUM_STAGES segments of SEG bits; stage k adds
// segment k using the registered carry of stage k-1 and registers the
// result together with the not-yet-added upper operand bits.
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : operand handshake
//   in_a, in_b, in_ci  : operands and carry-in (carry-in ignored in GF mode)
//   in_mode            : 0 integer add, 1 GF add (XOR)
//   out_valid/out_ready: result handshake
//   out_sum, out_co    : result and carry-out (carry-out 0 in GF mode)
//   out_mode           : mode of the beat being presented
module pipelined_gf_adder
    import gf_add_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_STAGES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic                  in_ci,
    input  logic                  in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_sum,
    output logic                  out_co,
    output logic                  out_mode
);

    localparam int unsigned SEG = seg_width(DATA_WIDTH, NUM_STAGES);

    logic [NUM_STAGES:0]   w_stage_ready;
    logic [NUM_STAGES-1:0] w_valid;

    // A stage may load when it is empty or when the stage after it is
    // moving; walked from the output back so bubbles collapse.
    always_comb begin
        w_stage_ready             = '0;
        w_stage_ready[NUM_STAGES] = out_ready;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            w_stage_ready[NUM_STAGES-1-i] = !w_valid[NUM_STAGES-1-i] ||
                                            w_stage_ready[NUM_STAGES-i];
        end
    end

    assign in_ready = w_stage_ready[0];

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        // Operand bits still to be added on entry to this stage, and sum
        // bits complete on exit from it.
        localparam int unsigned UP_W  = DATA_WIDTH - k * SEG;
        localparam int unsigned SUM_W = (k + 1) * SEG;

        logic [UP_W-1:0]  w_up_a;
        logic [UP_W-1:0]  w_up_b;
        logic             w_up_valid;
        logic             w_up_mode;
        logic             w_ci;
        logic [SEG-1:0]   w_sum;
        logic             w_co;
        logic [SUM_W-1:0] w_new_sum;

        stage_ctl_t       r_ctl;
        logic [SUM_W-1:0] r_sum;

        if (k == 0) begin : g_src
            assign w_up_a     = in_a;
            assign w_up_b     = in_b;
            assign w_up_valid = in_valid;
            assign w_up_mode  = in_mode;
            assign w_ci       = in_ci;
            assign w_new_sum  = w_sum;
        end else begin : g_src
            assign w_up_a     = g_stage[k-1].g_rem.r_a;
            assign w_up_b     = g_stage[k-1].g_rem.r_b;
            assign w_up_valid = g_stage[k-1].r_ctl.valid;
            assign w_up_mode  = g_stage[k-1].r_ctl.mode;
            assign w_ci       = g_stage[k-1].r_ctl.carry;
            assign w_new_sum  = {w_sum, g_stage[k-1].r_sum};
        end

        add_slice #(
            .SEG (SEG)
        ) u_slice (
            .a       (w_up_a[SEG-1:0]),
            .b       (w_up_b[SEG-1:0]),
            .ci      (w_ci),
            .gf_mode (w_up_mode),
            .sum     (w_sum),
            .co      (w_co)
        );

        // Payload only loads with a valid beat, so an empty output stage
        // keeps presenting its last (or reset) value.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_ctl <= '0;
                r_sum <= '0;
            end else if (w_stage_ready[k]) begin
                r_ctl.valid <= w_up_valid;
                if (w_up_valid) begin
                    r_ctl.mode  <= w_up_mode;
                    r_ctl.carry <= w_co;
                    r_sum       <= w_new_sum;
                end
            end
        end

        assign w_valid[k] = r_ctl.valid;

        if (k + 1 < NUM_STAGES) begin : g_rem
            logic [UP_W-SEG-1:0] r_a;
            logic [UP_W-SEG-1:0] r_b;

            always_ff @(posedge clk) begin
                if (w_stage_ready[k] && w_up_valid) begin
                    r_a <= w_up_a[UP_W-1:SEG];
                    r_b <= w_up_b[UP_W-1:SEG];
                end
            end
        end

        if (k == NUM_STAGES - 1) begin : g_out
            assign out_valid = r_ctl.valid;
            assign out_mode  = r_ctl.mode;
            assign out_co    = r_ctl.carry;
            assign out_sum   = r_sum;
        end
    end

endmodule

// File: tb/tb_pipelined_gf_adder.sv
module tb_pipelined_gf_adder;

    parameter int unsigned DW = 32;
    parameter int unsigned NS = 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic          in_ci;
    logic          in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_sum;
    logic          out_co;
    logic          out_mode;

    pipelined_gf_adder #(
        .DATA_WIDTH (DW),
        .NUM_STAGES (NS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_ci     (in_ci),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_co    (out_co),
        .out_mode  (out_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     n_tests = 0;
    int     n_fail  = 0;
    longint cyc     = 0;
    bit     checking = 1'b0;
    int     n_emitted = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] sum;
        logic          co;
        logic          mode;
        longint        t;
    } beat_t;

    beat_t q[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: plain arithmetic on the full width.
    function automatic logic [DW:0] ref_add(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic ci, input logic mode);
        logic [DW:0] r;
        if (mode) r = {1'b0, a ^ b};
        else      r = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, ci};
        return r;
    endfunction

    // Model: FIFO of accepted beats, each visible NS-1 edges after acceptance
    // once it reaches the head; NS slots of storage.
    always @(negedge clk) begin
        if (checking) begin
            logic exp_ready;
            logic exp_valid;
            exp_ready = (q.size() < NS) || out_ready;
            exp_valid = (q.size() > 0) && (cyc >= q[0].t + NS - 1);
            chk("in_ready", in_ready, exp_ready);
            chk("out_valid", out_valid, exp_valid);
            if (out_valid && q.size() > 0) begin
                chk("out_sum", out_sum, q[0].sum);
                chk("out_co", out_co, q[0].co);
                chk("out_mode", out_mode, q[0].mode);
            end
        end
        if (rst) begin
            q.delete();
        end else if (checking) begin
            if (out_valid && out_ready && q.size() > 0) begin
                void'(q.pop_front());
                n_emitted++;
            end
            if (in_valid && in_ready) begin
                beat_t b;
                logic [DW:0] r;
                r      = ref_add(in_a, in_b, in_ci, in_mode);
                b.sum  = r[DW-1:0];
                b.co   = r[DW];
                b.mode = in_mode;
                b.t    = cyc + 1;
                q.push_back(b);
            end
        end
    end

    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic ci,
                        input logic mode, output longint t, output bit stalled);
        bit ok;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_ci    = ci;
        in_mode  = mode;
        stalled  = 1'b0;
        ok       = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            stalled = 1'b1;
        end
        chk("send_accept_timeout", ok, 1'b1);
        @(posedge clk);
        #1;
        t        = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string name, output longint at);
        bit ok;
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
        chk(name, ok, 1'b1);
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (q.size() == 0) break;
        end
        chk(name, q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        longint t;
        longint at;
        bit     stalled;
        bit     any_stall;
        int     base;
        int     acc;
        int     cnt;
        int     sent;
        int     guard;
        logic [DW:0] r;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_ci     = 1'b0;
        in_mode   = 1'b0;
        out_ready = 1'b1;

        // Pin the model with hand-computed values.
        r = ref_add(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        chk("model_int_wrap", r, 33'h1_0000_0000);
        r = ref_add(32'hFFFF_FFFF, 32'h0F0F_0F0F, 1'b1, 1'b1);
        chk("model_gf", r, 33'h0_F0F0_F0F0);
        r = ref_add(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
        chk("model_int_ci", r, 33'h0_2345_678A);

        repeat (3) @(posedge clk);
        #1;
        checking = 1'b1;
        rst      = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_sum", out_sum, '0);
        chk("reset_out_co", out_co, 1'b0);
        chk("reset_out_mode", out_mode, 1'b0);
        chk("reset_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Integer wrap across every segment boundary.
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, t, stalled);
        wait_out("wrap_timeout", at);
        chk("wrap_latency", at, t + NS - 1);
        chk("wrap_sum", out_sum, 32'h0000_0000);
        chk("wrap_co", out_co, 1'b1);
        chk("wrap_mode", out_mode, 1'b0);
        drain("wrap_drain");

        // GF mode ignores carry-in.
        send(32'hFFFF_FFFF, 32'h0F0F_0F0F, 1'b1, 1'b1, t, stalled);
        wait_out("gf_timeout", at);
        chk("gf_latency", at, t + NS - 1);
        chk("gf_sum", out_sum, 32'hF0F0_F0F0);
        chk("gf_co", out_co, 1'b0);
        chk("gf_mode", out_mode, 1'b1);
        drain("gf_drain");

        // Streaming back-to-back, alternating mode.
        base      = n_emitted;
        any_stall = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send(DW'(i), DW'(16 * i), i[1], i[0], t, stalled);
            any_stall |= stalled;
        end
        chk("stream_in_ready_never_low", any_stall, 1'b0);
        drain("stream_drain");
        chk("stream_count", n_emitted - base, 8);

        // Backpressure: downstream stalled for 6 cycles.
        base      = n_emitted;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = $urandom;
        in_b      = $urandom;
        in_ci     = 1'($urandom);
        in_mode   = 1'b0;
        acc       = 0;
        for (int i = 0; i < 6; i++) begin
            bit took;
            @(negedge clk);
            took = in_ready;
            if (took) acc++;
            @(posedge clk);
            #1;
            if (took) begin
                in_a    = $urandom;
                in_b    = $urandom;
                in_ci   = 1'($urandom);
                in_mode = 1'($urandom);
            end
        end
        in_valid = 1'b0;
        chk("bp_accepted", acc, (NS < 6) ? NS : 6);
        @(negedge clk);
        chk("bp_in_ready", in_ready, (acc < NS) ? 1'b1 : 1'b0);
        repeat (3) @(posedge clk);
        #1;
        drain("bp_drain");
        chk("bp_delivered", n_emitted - base, acc);

        // Reset with beats in flight.
        for (int i = 0; i < 3; i++) begin
            send($urandom, $urandom, 1'($urandom), 1'($urandom), t, stalled);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_out_sum", out_sum, '0);
        chk("midrst_out_co", out_co, 1'b0);
        chk("midrst_out_mode", out_mode, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("midrst_no_stale", cnt, 0);
        @(posedge clk);
        #1;

        // Random traffic with random backpressure and carry-heavy operands.
        sent  = 0;
        guard = 0;
        base  = n_emitted;
        while (sent < 1000 && guard < 20000) begin
            bit took;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            in_a      = $urandom;
            in_b      = $urandom;
            case ($urandom_range(0, 7))
                0: in_a = '1;
                1: in_b = ~in_a;
                2: begin in_a = '1; in_b = '1; end
                default: ;
            endcase
            in_ci   = 1'($urandom);
            in_mode = 1'($urandom);
            @(negedge clk);
            took = in_valid && in_ready;
            if (took) sent++;
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        chk("rand_sent", sent, 1000);
        drain("rand_drain");
        chk("rand_delivered", n_emitted - base, sent);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
